// File: rtl/tiro_pkg.sv
// Shared types and geometry for the player-shot scheduler.
// Optional build macro: TIRO_AUTOFIRE_EN (level-sensitive autofire).
package tiro_pkg;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_COOLDOWN = 1'b1
    } tiro_state_t;

    localparam int SHOT_W = 2;
    localparam int SHOT_H = 8;
    localparam int X_W    = 11;
    localparam int Y_W    = 10;

endpackage

// File: rtl/tiro_slot_alloc.sv
// Lowest-free-index priority encoder for the shot slot pool.
// Purely combinational; all slot state lives in tiro_controller.
module tiro_slot_alloc #(
    parameter int N = 4
) (
    input  logic [N-1:0] free,
    output logic [2:0]   idx,
    output logic         any_free
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free[i]) idx = 3'(i);
        end
    end

    assign any_free = |free;

endmodule

// File: rtl/tiro_controller.sv
// Player shot scheduler: fire arbitration, slot pool, motion, pixel draw.
// Define TIRO_AUTOFIRE_EN for level-sensitive autofire; default is edge-only.
module tiro_controller
    import tiro_pkg::*;
#(
    parameter int N_SHOTS   = 4,
    parameter int COOLDOWN  = 25000000,
    parameter int SHOT_STEP = 8,
    parameter int SHOT_TOP  = 40,
    parameter int SHIP_Y    = 490,
    parameter int SHIP_XOFS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fire_n,
    input  logic                   frame_tick,
    input  logic [10:0]            posX_Nave,
    input  logic                   vivo,
    input  logic                   hit_valid,
    input  logic [2:0]             hit_idx,
    input  logic [9:0]             h_counter,
    input  logic [9:0]             v_counter,
    output logic [N_SHOTS-1:0]     shot_active,
    output logic [11*N_SHOTS-1:0]  shot_x,
    output logic [10*N_SHOTS-1:0]  shot_y,
    output logic                   fire_drop,
    output logic                   shot_on
);

    localparam int CNT_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [Y_W-1:0]   SPAWN_Y  = Y_W'(SHIP_Y - 8);
    localparam logic [Y_W-1:0]   MOVE_MIN = Y_W'(SHOT_TOP + SHOT_STEP);
    localparam logic [Y_W-1:0]   STEP     = Y_W'(SHOT_STEP);
    localparam logic [X_W-1:0]   XOFS     = X_W'(SHIP_XOFS);
    localparam logic [X_W:0]     SW_EXT   = (X_W + 1)'(SHOT_W);
    localparam logic [Y_W:0]     SH_EXT   = (Y_W + 1)'(SHOT_H);

    logic fire_s1, fire_s2, fire_s3;
    logic fire_edge, fire_evt;

    tiro_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic drop_q, drop_d;
    logic alloc;

    logic [N_SHOTS-1:0] active_q, active_d, free_mask;
    logic [X_W-1:0] x_q [N_SHOTS];
    logic [X_W-1:0] x_d [N_SHOTS];
    logic [Y_W-1:0] y_q [N_SHOTS];
    logic [Y_W-1:0] y_d [N_SHOTS];
    logic [2:0] alloc_idx;
    logic any_free;

    logic [X_W:0] hx;
    logic [Y_W:0] vy;
    logic on_d, on_q;

    // fire_s3 holds the previous synced sample so a press is one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_s1 <= 1'b1;
            fire_s2 <= 1'b1;
            fire_s3 <= 1'b1;
        end else begin
            fire_s1 <= fire_n;
            fire_s2 <= fire_s1;
            fire_s3 <= fire_s2;
        end
    end

    assign fire_edge = fire_s3 & ~fire_s2;

`ifdef TIRO_AUTOFIRE_EN
    logic idle_entry_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_entry_q <= 1'b0;
        end else begin
            idle_entry_q <= (state_q == S_COOLDOWN) && (state_d == S_IDLE);
        end
    end

    assign fire_evt = fire_edge | (idle_entry_q & ~fire_s2);
`else
    assign fire_evt = fire_edge;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        alloc   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fire_evt && vivo) begin
                    if (any_free) begin
                        alloc   = 1'b1;
                        state_d = S_COOLDOWN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else cnt_d = cnt_q - CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign free_mask = ~active_q;

    tiro_slot_alloc #(
        .N(N_SHOTS)
    ) u_alloc (
        .free    (free_mask),
        .idx     (alloc_idx),
        .any_free(any_free)
    );

    // hit beats spawn beats motion; a freed slot keeps its last x/y
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        for (int i = 0; i < N_SHOTS; i++) begin
            if (hit_valid && hit_idx == 3'(i)) begin
                active_d[i] = 1'b0;
            end else if (alloc && alloc_idx == 3'(i)) begin
                active_d[i] = 1'b1;
                x_d[i]      = posX_Nave + XOFS;
                y_d[i]      = SPAWN_Y;
            end else if (frame_tick && active_q[i]) begin
                if (y_q[i] >= MOVE_MIN) y_d[i] = y_q[i] - STEP;
                else active_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= '0;
            for (int i = 0; i < N_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            for (int i = 0; i < N_SHOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign hx = {2'b00, h_counter};
    assign vy = {1'b0, v_counter};

    always_comb begin
        on_d = 1'b0;
        for (int i = 0; i < N_SHOTS; i++) begin
            if (active_q[i]
                && hx >= {1'b0, x_q[i]}
                && hx <  {1'b0, x_q[i]} + SW_EXT
                && vy >= {1'b0, y_q[i]}
                && vy <  {1'b0, y_q[i]} + SH_EXT) begin
                on_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) on_q <= 1'b0;
        else on_q <= on_d;
    end

    always_comb begin
        shot_x = '0;
        shot_y = '0;
        for (int i = 0; i < N_SHOTS; i++) begin
            shot_x[X_W*i +: X_W] = x_q[i];
            shot_y[Y_W*i +: Y_W] = y_q[i];
        end
    end

    assign shot_active = active_q;
    assign fire_drop   = drop_q;
    assign shot_on     = on_q;

endmodule
